// File: rtl/alu_reservation_station.sv
// Reservation station for the single ALU: buffers decoded packets until both operands
// are resolved (snooping the CDB) and issues the lowest-index ready entry each cycle.
module alu_reservation_station #(
  parameter int                ENTRIES  = 4,
  parameter int                TAG_W    = 4,
  parameter logic [TAG_W-1:0]  TAG_FREE = 4'b1111,
  parameter int                DATA_W   = 32,
  parameter int                OP_W     = 5,
  localparam int               PKT_W    = 3*TAG_W + 2*DATA_W + OP_W,
  localparam int               CNT_W    = $clog2(ENTRIES) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [PKT_W-1:0]  in_pkt,
  output logic              rs_full,
  input  logic              flush,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  output logic              issue_valid,
  input  logic              alu_ready,
  output logic [OP_W-1:0]   issue_op,
  output logic [DATA_W-1:0] issue_src1,
  output logic [DATA_W-1:0] issue_src2,
  output logic [TAG_W-1:0]  issue_dest,
  output logic [CNT_W-1:0]  occupancy
);

  localparam int IDX_W   = $clog2(ENTRIES);
  localparam int D1_LSB  = OP_W;
  localparam int T1_LSB  = D1_LSB + DATA_W;
  localparam int D2_LSB  = T1_LSB + TAG_W;
  localparam int T2_LSB  = D2_LSB + DATA_W;
  localparam int DST_LSB = T2_LSB + TAG_W;

  logic [ENTRIES-1:0] slot_valid;
  logic [OP_W-1:0]    slot_op    [ENTRIES];
  logic [TAG_W-1:0]   slot_dest  [ENTRIES];
  logic [TAG_W-1:0]   slot_tag1  [ENTRIES];
  logic [TAG_W-1:0]   slot_tag2  [ENTRIES];
  logic [DATA_W-1:0]  slot_data1 [ENTRIES];
  logic [DATA_W-1:0]  slot_data2 [ENTRIES];
  logic [ENTRIES-1:0] slot_ready;

  logic [OP_W-1:0]   in_op;
  logic [TAG_W-1:0]  in_dest;
  logic [TAG_W-1:0]  in_tag1;
  logic [TAG_W-1:0]  in_tag2;
  logic [DATA_W-1:0] in_data1;
  logic [DATA_W-1:0] in_data2;
  logic              in_cap1;
  logic              in_cap2;
  logic [TAG_W-1:0]  new_tag1;
  logic [TAG_W-1:0]  new_tag2;
  logic [DATA_W-1:0] new_data1;
  logic [DATA_W-1:0] new_data2;

  logic             free_found;
  logic [IDX_W-1:0] free_idx;
  logic             sel_found;
  logic [IDX_W-1:0] sel_idx;
  logic             do_alloc;
  logic             do_issue;

  assign in_op    = in_pkt[0 +: OP_W];
  assign in_data1 = in_pkt[D1_LSB +: DATA_W];
  assign in_tag1  = in_pkt[T1_LSB +: TAG_W];
  assign in_data2 = in_pkt[D2_LSB +: DATA_W];
  assign in_tag2  = in_pkt[T2_LSB +: TAG_W];
  assign in_dest  = in_pkt[DST_LSB +: TAG_W];

  // The incoming packet snoops the CDB too, so a broadcast in its allocation cycle is not lost.
  assign in_cap1   = cdb_valid && (in_tag1 == cdb_tag) && (in_tag1 != TAG_FREE);
  assign in_cap2   = cdb_valid && (in_tag2 == cdb_tag) && (in_tag2 != TAG_FREE);
  assign new_tag1  = in_cap1 ? TAG_FREE : in_tag1;
  assign new_tag2  = in_cap2 ? TAG_FREE : in_tag2;
  assign new_data1 = in_cap1 ? cdb_data : in_data1;
  assign new_data2 = in_cap2 ? cdb_data : in_data2;

  always_comb begin
    slot_ready = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      slot_ready[i] = slot_valid[i] && (slot_tag1[i] == TAG_FREE) && (slot_tag2[i] == TAG_FREE);
    end
  end

  // Scanning from the top down lets the lowest matching index win for both searches.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    sel_found  = 1'b0;
    sel_idx    = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!slot_valid[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
      if (slot_ready[i]) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
  end

  assign rs_full  = (occupancy == CNT_W'(ENTRIES));
  assign do_alloc = in_valid && !rs_full && free_found && !flush;
  assign do_issue = sel_found && (!issue_valid || alu_ready) && !flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_valid <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        slot_op[i]    <= '0;
        slot_dest[i]  <= '0;
        slot_tag1[i]  <= TAG_FREE;
        slot_tag2[i]  <= TAG_FREE;
        slot_data1[i] <= '0;
        slot_data2[i] <= '0;
      end
    end else if (flush) begin
      slot_valid <= '0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (cdb_valid && slot_valid[i] && (slot_tag1[i] == cdb_tag) && (slot_tag1[i] != TAG_FREE)) begin
          slot_tag1[i]  <= TAG_FREE;
          slot_data1[i] <= cdb_data;
        end
        if (cdb_valid && slot_valid[i] && (slot_tag2[i] == cdb_tag) && (slot_tag2[i] != TAG_FREE)) begin
          slot_tag2[i]  <= TAG_FREE;
          slot_data2[i] <= cdb_data;
        end
        if (do_issue && (sel_idx == IDX_W'(i))) begin
          slot_valid[i] <= 1'b0;
        end
        // The free slot is invalid in registered state, so it never collides with the issuing slot.
        if (do_alloc && (free_idx == IDX_W'(i))) begin
          slot_valid[i] <= 1'b1;
          slot_op[i]    <= in_op;
          slot_dest[i]  <= in_dest;
          slot_tag1[i]  <= new_tag1;
          slot_tag2[i]  <= new_tag2;
          slot_data1[i] <= new_data1;
          slot_data2[i] <= new_data2;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occupancy <= '0;
    end else if (flush) begin
      occupancy <= '0;
    end else begin
      occupancy <= occupancy + CNT_W'(do_alloc) - CNT_W'(do_issue);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      issue_valid <= 1'b0;
      issue_op    <= '0;
      issue_src1  <= '0;
      issue_src2  <= '0;
      issue_dest  <= '0;
    end else if (flush) begin
      issue_valid <= 1'b0;
    end else if (do_issue) begin
      issue_valid <= 1'b1;
      issue_op    <= slot_op[sel_idx];
      issue_src1  <= slot_data1[sel_idx];
      issue_src2  <= slot_data2[sel_idx];
      issue_dest  <= slot_dest[sel_idx];
    end else if (alu_ready) begin
      issue_valid <= 1'b0;
    end
  end

endmodule
